// File: rtl/edge_fetch_pkg.sv
// edge_fetch_pkg: shared data width, default table size and walker state encoding
package edge_fetch_pkg;
  localparam int DATA_W = 32;
  localparam int MAX_NODES_DEF = 16;
  typedef enum logic [2:0] {IDLE, HDR, LOAD, EMIT, DONE} state_t;
endpackage

// File: rtl/edge_fetch_if.sv
// edge_fetch_if: data-memory port (a, rd) and edge stream (e_valid, e_ready, e_src, e_dst)
interface edge_fetch_if import edge_fetch_pkg::*; ();
  logic [15:0] a;
  logic [DATA_W-1:0] rd;
  logic e_valid, e_ready;
  logic [7:0] e_src, e_dst;
  modport master(output a, e_valid, e_src, e_dst, input rd, e_ready);
  modport slave(input a, e_valid, e_src, e_dst, output rd, e_ready);
endinterface

// File: rtl/edge_deg_table.sv
// edge_deg_table: per-node saturating degree counters, dual increment (src,dst), combinational read at raddr
module edge_deg_table #(
  parameter int MAX_NODES = 16,
  parameter int DEG_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic [7:0] src,
  input  logic [7:0] dst,
  input  logic [$clog2(MAX_NODES)-1:0] raddr,
  output logic [DEG_W-1:0] rdata
);
  logic [DEG_W-1:0] flat [MAX_NODES];
  for (genvar i = 0; i < MAX_NODES; i++) begin : g_n
    logic [DEG_W-1:0] q;
    logic [1:0] add;
    logic [DEG_W:0] sum;
    // a self-loop hits both compares and so counts twice; out-of-table endpoints hit nothing
    assign add = {1'b0, src == 8'(i)} + {1'b0, dst == 8'(i)};
    assign sum = {1'b0, q} + {{(DEG_W - 1){1'b0}}, add};
    always_ff @(posedge clk)
      q <= (rst || clr) ? '0 : !inc ? q : sum[DEG_W] ? '1 : sum[DEG_W-1:0];
    assign flat[i] = q;
  end
  assign rdata = flat[raddr];
endmodule

// File: rtl/edge_fetch.sv
// edge_fetch: walks a packed graph image in memory, streams its edges and accumulates node degrees
// ports: clk/rst; start+base launch a walk; bus carries memory address/data and the edge handshake;
// deg_addr/deg_data read the degree table; busy/done/err report walk status
module edge_fetch
  import edge_fetch_pkg::*;
#(
  parameter int MAX_NODES = MAX_NODES_DEF,
  parameter int DEG_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [15:0] base,
  edge_fetch_if.master bus,
  input  logic [$clog2(MAX_NODES)-1:0] deg_addr,
  output logic [DEG_W-1:0] deg_data,
  output logic busy,
  output logic done,
  output logic err
);
  localparam logic [8:0] LIM = 9'(MAX_NODES);
  state_t state, state_n;
  logic [15:0] a_q, cur, wbuf;
  logic [7:0] n, e_cnt, count;
  logic half, hs, bad, last, clr;
  assign hs = state == EMIT && bus.e_ready;
  assign last = count + 8'd1 == e_cnt;
  assign bad = cur[15:8] >= n || cur[7:0] >= n || {1'b0, cur[15:8]} >= LIM || {1'b0, cur[7:0]} >= LIM;
  assign clr = (state == IDLE || state == DONE) && start;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? HDR : state;
      HDR:        state_n = bus.rd[23:16] == 8'd0 ? DONE : EMIT;
      LOAD:       state_n = EMIT;
      EMIT:       state_n = !hs ? EMIT : last ? DONE : half ? EMIT : LOAD;
      default:    state_n = IDLE;
    endcase
  end
  // half=1 means the high half of the buffered word is on the bus and its low half is still pending
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      cur <= '0;
      wbuf <= '0;
      n <= '0;
      e_cnt <= '0;
      count <= '0;
      half <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (clr) begin
        a_q <= base;
        count <= '0;
        err <= 1'b0;
      end
      if (state == HDR) begin
        n <= bus.rd[31:24];
        e_cnt <= bus.rd[23:16];
        cur <= bus.rd[15:0];
        half <= 1'b0;
      end
      if (state == LOAD) begin
        wbuf <= bus.rd[15:0];
        cur <= bus.rd[31:16];
        half <= 1'b1;
      end
      if (hs) begin
        count <= count + 8'd1;
        err <= err | bad;
        if (!last && half) begin
          cur <= wbuf;
          half <= 1'b0;
        end
        if (!last && !half) a_q <= a_q + 16'd1;
      end
    end
  end
  assign bus.a = a_q;
  assign bus.e_valid = state == EMIT;
  assign bus.e_src = cur[15:8];
  assign bus.e_dst = cur[7:0];
  assign busy = state inside {HDR, LOAD, EMIT};
  assign done = state == DONE;
  edge_deg_table #(.MAX_NODES(MAX_NODES), .DEG_W(DEG_W)) u_deg (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(hs),
    .src(cur[15:8]),
    .dst(cur[7:0]),
    .raddr(deg_addr),
    .rdata(deg_data)
  );
endmodule
